ysyx_22040895_lsu: RTL and testbench



---
 rtl/ysyx_22040895_lsu_pkg.sv | 36 +++
 rtl/ysyx_22040895_lsu_align.sv | 66 ++++++
 rtl/ysyx_22040895_lsu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22040895_lsu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_unit_e  : access size encoding as carried on req_unit_i
//   lsu_state_e : control FSM states
//   LsuTimeoutDefault : default bus timeout in cycles spent in REQ+WAIT
//   is_misaligned() : natural-alignment check for a given size and byte offset
package ysyx_22040895_lsu_pkg;

   typedef enum logic [1:0] {
      UnitByte  = 2'b00,
      UnitHalf  = 2'b01,
      UnitWord  = 2'b10,
      UnitDword = 2'b11
   } lsu_unit_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StWait = 2'b10,
      StResp = 2'b11
   } lsu_state_e;

   localparam int unsigned LsuTimeoutDefault = 255;

   function automatic logic is_misaligned(input lsu_unit_e unit, input logic [2:0] off);
      logic r;
      unique case (unit)
         UnitByte:  r = 1'b0;
         UnitHalf:  r = off[0];
         UnitWord:  r = |off[1:0];
         UnitDword: r = |off;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   i_unit       access size
//   i_unsigned   zero-extend load result (ignored for dword)
//   i_off        byte offset inside the 8-byte bus word
//   i_wdata      right-aligned store data
//   i_rdata      aligned 8-byte read data from the bus
//   o_wstrb      byte strobes for a store of this size/offset
//   o_wdata      store data moved to its byte lane
//   o_misaligned access does not fall on its natural boundary
//   o_rdata      addressed lanes of i_rdata, truncated and extended
module ysyx_22040895_lsu_align
   import ysyx_22040895_lsu_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  lsu_unit_e        i_unit,
   input  logic             i_unsigned,
   input  logic [2:0]       i_off,
   input  logic [XLEN-1:0]  i_wdata,
   input  logic [XLEN-1:0]  i_rdata,
   output logic [7:0]       o_wstrb,
   output logic [XLEN-1:0]  o_wdata,
   output logic             o_misaligned,
   output logic [XLEN-1:0]  o_rdata
);

   logic [5:0]      w_shamt;
   logic [XLEN-1:0] w_rsh;

   assign w_shamt      = {i_off, 3'b000};
   assign o_wdata      = i_wdata << w_shamt;
   assign w_rsh        = i_rdata >> w_shamt;
   assign o_misaligned = is_misaligned(i_unit, i_off);

   always_comb begin
      o_wstrb = 8'h00;
      o_rdata = '0;
      unique case (i_unit)
         UnitByte: begin
            o_wstrb = 8'h01 << i_off;
            o_rdata = i_unsigned ? {{(XLEN-8){1'b0}}, w_rsh[7:0]}
                                 : {{(XLEN-8){w_rsh[7]}}, w_rsh[7:0]};
         end
         UnitHalf: begin
            o_wstrb = 8'h03 << i_off;
            o_rdata = i_unsigned ? {{(XLEN-16){1'b0}}, w_rsh[15:0]}
                                 : {{(XLEN-16){w_rsh[15]}}, w_rsh[15:0]};
         end
         UnitWord: begin
            o_wstrb = 8'h0F << i_off;
            o_rdata = i_unsigned ? {{(XLEN-32){1'b0}}, w_rsh[31:0]}
                                 : {{(XLEN-32){w_rsh[31]}}, w_rsh[31:0]};
         end
         UnitDword: begin
            o_wstrb = 8'hFF;
            o_rdata = w_rsh;
         end
         default: begin
            o_wstrb = 8'h00;
            o_rdata = '0;
         end
      endcase
   end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Multi-cycle load/store unit: one core request becomes one aligned 64-bit bus
// transaction with a valid/ready handshake, followed by a one-cycle response.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_*                        core request (valid/ready, we, size, unsigned, addr, wdata)
//   resp_valid_o/rdata_o/err_o   one-cycle completion with extended load data / error
//   busy_o                       core stall, includes the accept cycle
//   mem_valid_o .. mem_wstrb_o   bus request channel
//   mem_ready_i                  bus accepts request
//   mem_rvalid_i, mem_rdata_i    bus read data return
module ysyx_22040895_lsu
   import ysyx_22040895_lsu_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = LsuTimeoutDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [1:0]       req_unit_i,
   input  logic             req_unsigned_i,
   input  logic [XLEN-1:0]  req_addr_i,
   input  logic [XLEN-1:0]  req_wdata_i,
   output logic             resp_valid_o,
   output logic [XLEN-1:0]  resp_rdata_o,
   output logic             resp_err_o,
   output logic             busy_o,
   output logic             mem_valid_o,
   input  logic             mem_ready_i,
   output logic             mem_we_o,
   output logic [XLEN-1:0]  mem_addr_o,
   output logic [XLEN-1:0]  mem_wdata_o,
   output logic [7:0]       mem_wstrb_o,
   input  logic             mem_rvalid_i,
   input  logic [XLEN-1:0]  mem_rdata_i
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   lsu_state_e      r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_we;
   logic            r_uns;
   lsu_unit_e       r_unit;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_rdata;
   logic            r_err;

   logic            w_idle;
   logic            w_accept;
   logic            w_req;
   logic            w_resp;
   logic            w_tmo;
   lsu_unit_e       w_unit;
   logic [2:0]      w_off;
   logic [7:0]      w_wstrb;
   logic [XLEN-1:0] w_wdata_sh;
   logic            w_mis;
   logic [XLEN-1:0] w_rext;

   // Every output is forced low while rst is high, including mid-operation.
   assign w_idle   = (r_state == StIdle) & ~rst;
   assign w_req    = (r_state == StReq)  & ~rst;
   assign w_resp   = (r_state == StResp) & ~rst;
   assign w_accept = w_idle & req_valid_i;

   // Last cycle of the REQ+WAIT budget; a handshake/rvalid in this cycle still wins.
   assign w_tmo = (r_cnt >= CntW'(TIMEOUT - 1));

   // In IDLE the aligner looks at the incoming request (misalignment check);
   // afterwards it works from the registered request.
   assign w_unit = (r_state == StIdle) ? lsu_unit_e'(req_unit_i) : r_unit;
   assign w_off  = (r_state == StIdle) ? req_addr_i[2:0] : r_addr[2:0];

   ysyx_22040895_lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .i_unit       (w_unit),
      .i_unsigned   (r_uns),
      .i_off        (w_off),
      .i_wdata      (r_wdata),
      .i_rdata      (mem_rdata_i),
      .o_wstrb      (w_wstrb),
      .o_wdata      (w_wdata_sh),
      .o_misaligned (w_mis),
      .o_rdata      (w_rext)
   );

   assign req_ready_o  = w_idle;
   assign busy_o       = ~rst & ((r_state != StIdle) | w_accept);
   assign resp_valid_o = w_resp;
   assign resp_rdata_o = w_resp ? r_rdata : '0;
   assign resp_err_o   = w_resp & r_err;
   assign mem_valid_o  = w_req;
   assign mem_we_o     = w_req & r_we;
   assign mem_addr_o   = w_req ? {r_addr[XLEN-1:3], 3'b000} : '0;
   assign mem_wdata_o  = (w_req & r_we) ? w_wdata_sh : '0;
   assign mem_wstrb_o  = (w_req & r_we) ? w_wstrb : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_unit  <= UnitByte;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_we    <= req_we_i;
                  r_uns   <= req_unsigned_i;
                  r_unit  <= lsu_unit_e'(req_unit_i);
                  r_addr  <= req_addr_i;
                  r_wdata <= req_wdata_i;
                  r_rdata <= '0;
                  r_cnt   <= '0;
                  if (w_mis) begin
                     r_err   <= 1'b1;
                     r_state <= StResp;
                  end else begin
                     r_err   <= 1'b0;
                     r_state <= StReq;
                  end
               end
            end
            StReq: begin
               if (mem_ready_i) begin
                  r_cnt   <= r_cnt + CntW'(1);
                  r_state <= r_we ? StResp : StWait;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_state <= StResp;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StWait: begin
               if (mem_rvalid_i) begin
                  r_rdata <= w_rext;
                  r_state <= StResp;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_state <= StResp;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StResp: begin
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Self-checking bench for ysyx_22040895_lsu: directed cases plus randomized
// transactions checked cycle by cycle against a behavioural model.
module tb_ysyx_22040895_lsu;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_unit_i;
   logic        req_unsigned_i;
   logic [63:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic        resp_valid_o;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;
   logic        busy_o;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wstrb_o;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ysyx_22040895_lsu #(
      .XLEN    (64),
      .TIMEOUT (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_unit_i     (req_unit_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .resp_valid_o   (resp_valid_o),
      .resp_rdata_o   (resp_rdata_o),
      .resp_err_o     (resp_err_o),
      .busy_o         (busy_o),
      .mem_valid_o    (mem_valid_o),
      .mem_ready_i    (mem_ready_i),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_wstrb_o    (mem_wstrb_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Load result: pick size bytes at the offset, then sign- or zero-extend.
   function automatic logic [63:0] model_load(input int unit, input bit uns, input int off,
                                              input logic [63:0] d);
      int          nb;
      logic [63:0] v;
      logic [63:0] mask;
      nb   = 1 << unit;
      v    = d >> (off * 8);
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
      v    = v & mask;
      if (!uns && nb < 8 && v[nb*8-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req_ready"}, req_ready_o, 0);
      check_eq({tag, "_busy"}, busy_o, 0);
      check_eq({tag, "_resp_valid"}, resp_valid_o, 0);
      check_eq({tag, "_resp_rdata"}, resp_rdata_o, 0);
      check_eq({tag, "_resp_err"}, resp_err_o, 0);
      check_eq({tag, "_mem_valid"}, mem_valid_o, 0);
      check_eq({tag, "_mem_we"}, mem_we_o, 0);
      check_eq({tag, "_mem_addr"}, mem_addr_o, 0);
      check_eq({tag, "_mem_wdata"}, mem_wdata_o, 0);
      check_eq({tag, "_mem_wstrb"}, mem_wstrb_o, 0);
   endtask

   // One full transaction. rdly: cycles after entering REQ until mem_ready pulses;
   // vdly: cycles after entering WAIT until mem_rvalid pulses.
   task automatic run_txn(input bit we, input int unit, input bit uns, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata,
                          input int rdly, input int vdly);
      int          off, nb, k_w, k_f, k_e, t_resp, t_req_end;
      bit          mis, ok;
      logic [63:0] exp_strb, exp_wdata, exp_rdata, exp_addr;
      off       = int'(addr[2:0]);
      nb        = 1 << unit;
      mis       = (off % nb) != 0;
      exp_strb  = ((64'd1 << nb) - 64'd1) << off;
      exp_wdata = wdata << (off * 8);
      exp_rdata = model_load(unit, uns, off, rdata);
      exp_addr  = addr & ~64'd7;
      k_e       = -100;
      if (mis) begin
         ok = 0; t_resp = 1; t_req_end = 0;
      end else if (rdly > int'(TMO) - 1) begin
         ok = 0; t_req_end = TMO; t_resp = TMO + 1;
      end else begin
         t_req_end = 1 + rdly;
         if (we) begin
            ok = 1; t_resp = t_req_end + 1;
         end else begin
            k_w    = rdly + 1;
            k_f    = (k_w > int'(TMO) - 1) ? k_w : int'(TMO) - 1;
            k_e    = k_w + vdly;
            ok     = (k_e <= k_f);
            t_resp = 1 + (ok ? k_e : k_f) + 1;
         end
      end

      @(posedge clk); #1;
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_unit_i     = 2'(unit);
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wdata;
      mem_rdata_i    = rdata;
      mem_ready_i    = 1'b0;
      mem_rvalid_i   = 1'b0;
      @(negedge clk);
      check_eq("t0_req_ready", req_ready_o, 1);
      check_eq("t0_busy", busy_o, 1);
      check_eq("t0_resp_valid", resp_valid_o, 0);

      for (int t = 1; t <= t_resp + 1; t++) begin
         @(posedge clk); #1;
         req_valid_i  = 1'b0;
         req_addr_i   = {$urandom, $urandom};
         req_wdata_i  = {$urandom, $urandom};
         mem_ready_i  = (t - 1 == rdly);
         // Stray rvalid during REQ must be ignored.
         mem_rvalid_i = (!we && (t - 1 == k_e)) || ((t - 1 < rdly) && ($urandom_range(0, 1) == 1));
         @(negedge clk);
         check_eq("resp_valid", resp_valid_o, (t == t_resp) ? 1 : 0);
         check_eq("mem_valid", mem_valid_o, (!mis && t <= t_req_end) ? 1 : 0);
         check_eq("busy", busy_o, (t <= t_resp) ? 1 : 0);
         check_eq("req_ready", req_ready_o, (t > t_resp) ? 1 : 0);
         if (!mis && t <= t_req_end) begin
            check_eq("mem_addr", mem_addr_o, exp_addr);
            check_eq("mem_we", mem_we_o, we);
            check_eq("mem_wstrb", mem_wstrb_o, we ? exp_strb : 64'd0);
            if (we) check_eq("mem_wdata", mem_wdata_o, exp_wdata);
         end
         if (t == t_resp) begin
            check_eq("resp_err", resp_err_o, ok ? 0 : 1);
            check_eq("resp_rdata", resp_rdata_o, (ok && !we) ? exp_rdata : 64'd0);
         end else begin
            check_eq("resp_err_idle", resp_err_o, 0);
            check_eq("resp_rdata_idle", resp_rdata_o, 0);
         end
      end
   endtask

   initial begin
      int          u, rd, vd;
      bit          w, us;
      logic [63:0] a;

      rst            = 1'b1;
      req_valid_i    = 1'b1;
      req_we_i       = 1'b0;
      req_unit_i     = 2'b11;
      req_unsigned_i = 1'b0;
      req_addr_i     = 64'h8000_0000;
      req_wdata_i    = '0;
      mem_ready_i    = 1'b0;
      mem_rvalid_i   = 1'b0;
      mem_rdata_i    = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst         = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk);
      check_eq("post_reset_req_ready", req_ready_o, 1);
      check_eq("post_reset_busy", busy_o, 0);

      // Directed cases.
      run_txn(0, 0, 0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
      run_txn(1, 1, 0, 64'h8000_0006, 64'h1234, 64'd0, 0, 0);
      run_txn(0, 2, 1, 64'h8000_0004, 64'd0, 64'h89AB_CDEF_0123_4567, 3, 0);
      run_txn(0, 2, 0, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
      run_txn(1, 3, 0, 64'h8000_0001, 64'h55, 64'd0, 0, 0);
      run_txn(0, 3, 0, 64'h8000_0008, 64'd0, 64'h1, 10, 0);
      run_txn(0, 1, 0, 64'h8000_000A, 64'd0, 64'hFFFF_0000_0000_0000, 0, 5);
      run_txn(0, 1, 0, 64'h8000_000E, 64'd0, 64'hF00D_0000_0000_0000, 0, 2);

      // Randomized transactions.
      for (int i = 0; i < 60; i++) begin
         u  = $urandom_range(0, 3);
         w  = $urandom_range(0, 1) == 1;
         us = $urandom_range(0, 1) == 1;
         rd = $urandom_range(0, 5);
         vd = $urandom_range(0, 4);
         a  = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a[2:0] = 3'((1 << u) * $urandom_range(0, (8 >> u) - 1));
         run_txn(w, u, us, a, {$urandom, $urandom}, {$urandom, $urandom}, rd, vd);
      end

      // Reset while in WAIT, late rvalid afterwards must be ignored.
      @(posedge clk); #1;
      req_valid_i    = 1'b1;
      req_we_i       = 1'b0;
      req_unit_i     = 2'b11;
      req_unsigned_i = 1'b0;
      req_addr_i     = 64'h8000_0010;
      mem_rdata_i    = 64'hDEAD_BEEF_CAFE_F00D;
      mem_ready_i    = 1'b0;
      mem_rvalid_i   = 1'b0;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      mem_ready_i = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_mem_valid", mem_valid_o, 1);
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
      rst         = 1'b1;
      @(negedge clk);
      check_all_zero("rst_in_wait");
      @(posedge clk); #1;
      rst          = 1'b0;
      mem_rvalid_i = 1'b1;
      @(negedge clk);
      check_eq("late_rvalid_resp_valid", resp_valid_o, 0);
      check_eq("late_rvalid_busy", busy_o, 0);
      check_eq("late_rvalid_mem_valid", mem_valid_o, 0);
      check_eq("late_rvalid_req_ready", req_ready_o, 1);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      check_eq("after_rst_resp_valid", resp_valid_o, 0);

      run_txn(0, 2, 0, 64'h8000_0014, 64'd0, 64'h8765_4321_0000_0000, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
